// File: rtl/ibex_rf_mp_pkg.sv
// Shared types and sizing helpers for the multi-port register file and its
// per-register access counters.
package ibex_rf_mp_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam int NumRegsFull = 32;
  localparam int NumRegsE    = 16;

  function automatic int num_regs(input bit rv32e);
    return rv32e ? NumRegsE : NumRegsFull;
  endfunction

endpackage

// File: rtl/ibex_rf_access_cnt.sv
// One saturating access counter: adds the per-cycle access count, or restarts
// from that count when cleared so that accesses in the clearing cycle are kept.
module ibex_rf_access_cnt #(
  parameter int CntWidth = 16,
  parameter int IncWidth = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IncWidth-1:0] inc_i,
  input  logic                clr_i,
  output logic [CntWidth-1:0] cnt_o
);

  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth:0]   sum;

  // One extra bit catches the carry out so the counter can pin at all-ones.
  assign sum = {1'b0, cnt_q} + {{(CntWidth + 1 - IncWidth){1'b0}}, inc_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= {{(CntWidth - IncWidth){1'b0}}, inc_i};
    end else if (sum[CntWidth]) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= sum[CntWidth-1:0];
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop register file with per-register access counters.
// Define IBEX_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module ibex_register_file_mp
  import ibex_rf_mp_pkg::*;
#(
  parameter bit RV32E     = 1'b0,
  parameter int DataWidth = 32,
  parameter int NumRead   = 2,
  parameter int NumWrite  = 1,
  parameter int CntWidth  = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumRead-1:0]                  re_i,
  input  logic [NumRead-1:0][4:0]             raddr_i,
  output logic [NumRead-1:0][DataWidth-1:0]   rdata_o,
  input  logic [NumWrite-1:0]                 we_i,
  input  logic [NumWrite-1:0][4:0]            waddr_i,
  input  logic [NumWrite-1:0][DataWidth-1:0]  wdata_i,
  input  logic                                cnt_req_i,
  input  logic [4:0]                          cnt_addr_i,
  input  logic                                cnt_clr_i,
  output logic                                cnt_valid_o,
  output logic [CntWidth-1:0]                 cnt_rdata_o
);

  localparam int NumRegs  = num_regs(RV32E);
  localparam int IncWidth = $clog2(NumRead + NumWrite + 1);

  logic [DataWidth-1:0] rf_q [1:NumRegs-1];
  logic [IncWidth-1:0]  inc [NumRegs];
  logic [CntWidth-1:0]  cnt [NumRegs];
  logic [NumRegs-1:0]   clr;
  logic [CntWidth-1:0]  cnt_sel;

  // Full 5-bit compares against existing indices make x0 and the RV32E upper
  // half fall out naturally: they match no stored register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 1; r < NumRegs; r++) rf_q[r] <= '0;
    end else begin
      for (int r = 1; r < NumRegs; r++) begin
        for (int w = 0; w < NumWrite; w++) begin
          if (we_i[w] && (waddr_i[w] == reg_addr_t'(r))) rf_q[r] <= wdata_i[w];
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NumRead; p++) begin
      for (int r = 1; r < NumRegs; r++) begin
        if (raddr_i[p] == reg_addr_t'(r)) begin
          rdata_o[p] = rf_q[r];
`ifdef IBEX_RF_BYPASS_EN
          for (int w = 0; w < NumWrite; w++) begin
            if (we_i[w] && (waddr_i[w] == reg_addr_t'(r))) rdata_o[p] = wdata_i[w];
          end
`endif
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NumRegs; r++) begin
      inc[r] = '0;
      for (int p = 0; p < NumRead; p++) begin
        if (re_i[p] && (raddr_i[p] == reg_addr_t'(r))) inc[r] = inc[r] + IncWidth'(1);
      end
      for (int w = 0; w < NumWrite; w++) begin
        if (we_i[w] && (waddr_i[w] == reg_addr_t'(r))) inc[r] = inc[r] + IncWidth'(1);
      end
    end
  end

  for (genvar r = 0; r < NumRegs; r++) begin : g_cnt
    assign clr[r] = cnt_req_i & cnt_clr_i & (cnt_addr_i == reg_addr_t'(r));

    ibex_rf_access_cnt #(
      .CntWidth (CntWidth),
      .IncWidth (IncWidth)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (inc[r]),
      .clr_i (clr[r]),
      .cnt_o (cnt[r])
    );
  end

  always_comb begin
    cnt_sel = '0;
    for (int r = 0; r < NumRegs; r++) begin
      if (cnt_addr_i == reg_addr_t'(r)) cnt_sel = cnt[r];
    end
  end

  // Readout captures the pre-increment value; data holds until the next request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_valid_o <= 1'b0;
      cnt_rdata_o <= '0;
    end else begin
      cnt_valid_o <= cnt_req_i;
      if (cnt_req_i) cnt_rdata_o <= cnt_sel;
    end
  end

endmodule
